uart_irda_rx_core: RTL and testbench
====================================

// Module: uart_irda_rx_core
// PURPOSE
//  Parametrised serial receiver for the UART/IrDA link. Successor to the fixed 8N1 receiver.
//  Adds configurable data width, parity mode, stop bits and input polarity, plus 3-sample
//  majority voting and a per-word error-tagged output FIFO with valid/ready handshake.
//  Sits between the IR demodulator output pin and the host logic / display decoders.
// PARAMETERS
//  CLK_DIV     16  clocks per bit period (>=8)
//  DATA_BITS   8   data bits per frame, 5..9, LSB first
//  PARITY_MODE 1   0=none, 1=even, 2=odd
//  STOP_BITS   1   1 or 2
//  RX_INVERT   0   1: rx_data inverted before sync (IrDA active-high pulse receivers)
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >=2
// PORTS
//  clock        in   1              system clock, rising edge
//  reset        in   1              asynchronous, active-low; all state cleared while 0
//  rx_data      in   1              serial line, idle high after optional inversion
//  clear_err    in   1              1-cycle pulse clears sticky overrun_err
//  rx_ready     in   1              consumer accepts head word this cycle
//  rx_valid     out  1              FIFO non-empty; head word on rx_word
//  rx_word      out  DATA_BITS      head data word
//  parity_err   out  1              head word parity mismatch (0 if PARITY_MODE=0)
//  frame_err    out  1              head word had a 0 in any stop bit
//  overrun_err  out  1              sticky: a completed word was dropped (FIFO full)
//  busy         out  1              receiver not in IDLE
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  words held
// BEHAVIOUR
//  Reset: FSM=IDLE, counters 0, FIFO empty; rx_valid=0, rx_word=0, parity_err=0,
//   frame_err=0, overrun_err=0, busy=0, fifo_count=0. Sync flops reset to 1 (idle).
//  Input: rx_data^RX_INVERT through 2-FF synchroniser; 'rxs' = synchronised value.
//  Bit counter runs 0..CLK_DIV-1. Samples taken at counts M-1, M, M+1 (M=CLK_DIV/2);
//   bit value = majority of 3, decided at count M+1.
//  FSM:
//   IDLE   : rxs 1->0 edge -> START, counter=0.
//   START  : at decision, bit=1 -> IDLE (false start, nothing pushed); bit=0 -> DATA.
//   DATA   : DATA_BITS decisions, shifted in LSB first -> PARITY if PARITY_MODE!=0 else STOP.
//   PARITY : one decision; parity_err = (XOR(data)^bit) != (PARITY_MODE==2).
//   STOP   : STOP_BITS decisions; frame_err |= ~bit for each. After last decision -> push,
//            then REARM if frame_err else IDLE.
//   REARM  : wait until rxs==1 for one full CLK_DIV period, then IDLE (break-safe: no
//            retrigger while line held low).
//  Push: entry {frame_err, parity_err, data} written the cycle after the last stop decision;
//   rx_valid asserts the following cycle if FIFO was empty (stop-sample -> rx_valid = 2 clocks).
//  Pop: rx_valid & rx_ready; next entry presented next cycle.
//  Full: push accepted if not full OR pop in same cycle; otherwise word dropped and
//   overrun_err set; FIFO contents unchanged.
//  Empty: rx_ready ignored while rx_valid=0; outputs hold last value.
//  overrun_err: set by drop, cleared by clear_err; drop+clear same cycle -> stays 1.
//  Pointers wrap modulo FIFO_DEPTH; fifo_count is exact 0..FIFO_DEPTH.
//  Reset mid-frame: partial word discarded, FIFO flushed, FSM to IDLE asynchronously.
//  Error flags are per-word; no frame aborts early on error.
// TESTING (CLK_DIV=16, DATA_BITS=8, even parity, 1 stop unless stated)
//  1. Frame 0xA5, parity 0, stop 1 -> rx_word=0xA5, parity_err=0, frame_err=0,
//     rx_valid 2 clocks after stop decision.
//  2. 0x3C with parity bit 1 -> parity_err=1; PARITY_MODE=2 same frame -> parity_err=0.
//  3. 0x55 with stop bit 0, then line held low 40 bit-times -> one word, frame_err=1;
//     no further pushes until line high 16 clocks.
//  4. Start glitch low for 4 clocks -> busy pulses, returns IDLE, fifo_count stays 0.
//  5. rx_ready=0, send 5 words (DEPTH=4) -> fifo_count=4, overrun_err=1, words 1..4 in
//     order; clear_err -> overrun_err=0.
//  6. Single-clock spike inverting mid-bit sample of 0xFF -> majority keeps 0xFF;
//     reset low mid-DATA -> all outputs 0, next clean frame received correctly.

Source files
------------

// File: rtl/uart_irda_rx_core.sv
// Parametrised UART/IrDA serial receiver: 2-FF synchroniser, 3-sample majority vote,
// configurable frame format and an error-tagged output FIFO with valid/ready handshake.
module uart_irda_rx_core #(
  parameter int CLK_DIV     = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int RX_INVERT   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_data,
  input  logic                          clear_err,
  input  logic                          rx_ready,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_word,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] SAMP_A    = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] SAMP_B    = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] SAMP_C    = CW'(CLK_DIV / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_MODE == 2);
  localparam logic          INV       = (RX_INVERT != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_REARM} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic sync1_q, sync2_q, rxs_prev_q, rxs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_data ^ INV;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
    end
  end

  assign rxs = sync2_q;

  state_t               state_q;
  logic [CW-1:0]        cnt_q, cnt_next_d;
  logic [1:0]           samp_q;
  logic [BW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q, push_q, busy_q;
  logic                 decide, bit_d, ferr_d;

  assign cnt_next_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign decide     = (cnt_q == SAMP_C);
  assign bit_d      = maj3(samp_q[0], samp_q[1], rxs);
  assign ferr_d     = ferr_q | ~bit_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      samp_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (cnt_q == SAMP_A) samp_q[0] <= rxs;
      if (cnt_q == SAMP_B) samp_q[1] <= rxs;
      case (state_q)
        S_IDLE: begin
          if (rxs_prev_q && !rxs) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          cnt_q <= cnt_next_d;
          if (decide) begin
            if (bit_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= S_DATA;
              bit_idx_q  <= '0;
              stop_idx_q <= 1'b0;
              perr_q     <= 1'b0;
              ferr_q     <= 1'b0;
            end
          end
        end
        S_DATA: begin
          cnt_q <= cnt_next_d;
          if (decide) begin
            shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_DATA) state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            else                        bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        S_PARITY: begin
          cnt_q <= cnt_next_d;
          if (decide) begin
            perr_q  <= ((^shift_q) ^ bit_d) != ODD;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          cnt_q <= cnt_next_d;
          if (decide) begin
            ferr_q <= ferr_d;
            if (stop_idx_q == STOP_LAST) begin
              push_q <= 1'b1;
              if (ferr_d) begin
                state_q <= S_REARM;
                cnt_q   <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        // A held-low break must be followed by a full bit period of idle before re-arming.
        S_REARM: begin
          if (!rxs) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [EW-1:0] head_q, head_d, entry_d;
  logic          ovr_q, pop, push_ok;

  assign pop      = rx_ready & (count_q != '0);
  assign push_ok  = push_q & ((count_q != NW'(FIFO_DEPTH)) | pop);
  assign entry_d  = {ferr_q, perr_q, shift_q};
  assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Head is registered so it holds the last word once the FIFO drains.
  assign head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? entry_d : mem_q[rd_ptr_d];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry_d;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (count_d != '0) head_q <= head_d;
      if (push_q && !push_ok) ovr_q <= 1'b1;
      else if (clear_err)     ovr_q <= 1'b0;
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_word     = head_q[DATA_BITS-1:0];
  assign parity_err  = head_q[DATA_BITS];
  assign frame_err   = head_q[DATA_BITS+1];
  assign overrun_err = ovr_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_irda_rx_core.sv
// Bench for uart_irda_rx_core: directed frames plus random frames checked against a
// queue-based model of the word FIFO built from the frame bits the bench transmits.
`timescale 1ns/1ps
module tb_uart_irda_rx_core;
  localparam int CLK_DIV = 16;
  localparam int M       = CLK_DIV / 2;
  localparam int DEPTH   = 4;

  logic       clock = 1'b0, reset = 1'b0, rx_data = 1'b1, clear_err = 1'b0;
  logic       rx_ready = 1'b0, rx_ready_o = 1'b1;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;
  logic [7:0] rx_word;
  logic [2:0] fifo_count;
  logic       rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o;
  logic [7:0] rx_word_o;
  logic [2:0] fifo_count_o;

  uart_irda_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                      .RX_INVERT(0), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .clear_err(clear_err),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_word(rx_word), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy), .fifo_count(fifo_count));

  uart_irda_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                      .RX_INVERT(0), .FIFO_DEPTH(DEPTH)) dut_odd (
    .clock(clock), .reset(reset), .rx_data(rx_data), .clear_err(clear_err),
    .rx_ready(rx_ready_o), .rx_valid(rx_valid_o), .rx_word(rx_word_o),
    .parity_err(parity_err_o), .frame_err(frame_err_o), .overrun_err(overrun_err_o),
    .busy(busy_o), .fifo_count(fifo_count_o));

  always #5 clock = ~clock;

  typedef struct packed { logic fe; logic pe; logic [7:0] d; } entry_t;

  int     tests_run = 0, tests_failed = 0;
  int     cyc = 0, busy_at = 0, valid_at = 0;
  entry_t model_q[$];
  logic   model_ovr = 1'b0;
  entry_t last_pop = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (busy && busy_at < 0) busy_at = cyc;
    if (rx_valid && valid_at < 0) valid_at = cyc;
  endtask

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic b, input logic spike);
    for (int c = 0; c < CLK_DIV; c++) begin
      rx_data = (spike && c == M + 1) ? ~b : b;
      tick();
    end
  endtask

  function automatic logic even_pbit(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // spike_bit selects which frame bit (0=start .. 10=stop) gets a one-clock inversion.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input int spike_bit);
    entry_t e;
    drive_bit(1'b0, spike_bit == 0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], spike_bit == i + 1);
    drive_bit(pbit, spike_bit == 9);
    drive_bit(stopb, spike_bit == 10);
    e.d  = d;
    e.pe = (pbit != even_pbit(d));
    e.fe = ~stopb;
    if (model_q.size() < DEPTH) model_q.push_back(e);
    else                        model_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    entry_t e;
    int     w;
    w = 0;
    while (!rx_valid && w < 64) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, 32'(rx_valid), 32'(1));
    e = '0;
    if (model_q.size() > 0) e = model_q.pop_front();
    chk({tag, "_word"}, 32'(rx_word), 32'(e.d));
    chk({tag, "_pe"}, 32'(parity_err), 32'(e.pe));
    chk({tag, "_fe"}, 32'(frame_err), 32'(e.fe));
    last_pop = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'(0));
    chk({tag, "_word"}, 32'(rx_word), 32'(0));
    chk({tag, "_pe"}, 32'(parity_err), 32'(0));
    chk({tag, "_fe"}, 32'(frame_err), 32'(0));
    chk({tag, "_ovr"}, 32'(overrun_err), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_count"}, 32'(fifo_count), 32'(0));
  endtask

  initial begin
    logic [7:0] d;
    logic       pflip, stopb, seen;

    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b1;
    idle(20);

    // Basic frame and stop-sample to rx_valid latency.
    busy_at  = -1;
    valid_at = -1;
    send_frame(8'hA5, even_pbit(8'hA5), 1'b1, -1);
    idle(8);
    chk("t1_latency", 32'(valid_at - busy_at), 32'((M + 1) + 10 * CLK_DIV + 2));
    pop_check("t1");

    // Wrong even parity bit; the odd-parity instance sees the same bit as correct.
    rx_ready_o = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle(20);
    pop_check("t2");
    chk("t2_odd_valid", 32'(rx_valid_o), 32'(1));
    chk("t2_odd_word", 32'(rx_word_o), 32'(8'h3C));
    chk("t2_odd_pe", 32'(parity_err_o), 32'(0));
    rx_ready_o = 1'b1;
    tick();

    // Break: stop bit low and line held low 40 bit-times.
    send_frame(8'h55, even_pbit(8'h55), 1'b0, -1);
    rx_data = 1'b0;
    repeat (40 * CLK_DIV) tick();
    chk("t3_count", 32'(fifo_count), 32'(1));
    chk("t3_busy_low", 32'(busy), 32'(1));
    rx_data = 1'b1;
    repeat (10) tick();
    chk("t3_busy_rearm", 32'(busy), 32'(1));
    repeat (20) tick();
    chk("t3_busy_idle", 32'(busy), 32'(0));
    pop_check("t3");

    // Short start glitch.
    seen    = 1'b0;
    rx_data = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx_data = 1'b1;
      tick();
      if (busy) seen = 1'b1;
    end
    chk("t4_busy_pulse", 32'(seen), 32'(1));
    chk("t4_busy_end", 32'(busy), 32'(0));
    chk("t4_count", 32'(fifo_count), 32'(0));

    // Overrun: five words into a four-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, even_pbit(d), 1'b1, -1);
      idle(24);
    end
    chk("t5_count", 32'(fifo_count), 32'(DEPTH));
    chk("t5_ovr", 32'(overrun_err), 32'(model_ovr));
    for (int i = 0; i < DEPTH; i++) pop_check("t5");
    rx_ready = 1'b1;
    repeat (4) tick();
    rx_ready = 1'b0;
    chk("t5_empty_count", 32'(fifo_count), 32'(0));
    chk("t5_empty_valid", 32'(rx_valid), 32'(0));
    chk("t5_hold_word", 32'(rx_word), 32'(last_pop.d));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    model_ovr = 1'b0;
    chk("t5_clear", 32'(overrun_err), 32'(model_ovr));

    // Mid-bit spike rejected by majority vote.
    send_frame(8'hFF, even_pbit(8'hFF), 1'b1, 4);
    idle(20);
    pop_check("t6_spike");

    // Reset in the middle of a data field with a word already queued.
    d = 8'($urandom_range(0, 255));
    send_frame(d, even_pbit(d), 1'b1, -1);
    idle(24);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk_zero("t6_rst");
    model_q.delete();
    model_ovr = 1'b0;
    rx_data   = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    idle(20);
    d = 8'($urandom_range(0, 255));
    send_frame(d, even_pbit(d), 1'b1, -1);
    idle(20);
    pop_check("t6_after");

    // Random frames with occasional parity and stop-bit errors.
    for (int n = 0; n < 10; n++) begin
      d     = 8'($urandom_range(0, 255));
      pflip = ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 3) != 0);
      send_frame(d, even_pbit(d) ^ pflip, stopb, -1);
      idle(24 + int'($urandom_range(0, 7)));
      pop_check("rnd");
    end
    chk("end_ovr", 32'(overrun_err), 32'(model_ovr));
    chk("end_count", 32'(fifo_count), 32'(model_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
